// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the memory macro and the arbiter.
// The arbiter takes the slave view; the requester/memory side takes the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          addr_sel;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  addr_sel, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output addr_sel, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and data accesses,
// tracks the one in-flight read and steers its returning data to the requester that issued it.
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [2:0] CNT_INIT   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam int         NPORT      = 2;   // index 0 = fetch, 1 = data

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       owner_reg, owner_next;
    logic [3:0] starve_reg, starve_next;
    logic       addr_sel_reg, addr_sel_next;

    logic          port_free;
    logic          ret_cycle;
    logic          if_win;
    logic          d_win;
    logic          issue;
    logic          addr_sel_out;
    logic [AW-1:0] addr_mux;

    logic [NPORT-1:0] rvalid_vec;
    logic [DW-1:0]    rdata_vec [NPORT];

    // The return cycle of a read also frees the port, so reads can run back to back.
    assign port_free = (state_reg == IDLE) || (cnt_reg == 3'd0);
    assign ret_cycle = rst_n && (state_reg == WAIT) && (cnt_reg == 3'd0);

    // Grants are gated by rst_n so nothing is issued while reset is held.
    assign if_win = rst_n && port_free && bus.if_req &&
                    (!bus.d_req || (starve_reg == STARVE_LIM));
    assign d_win  = rst_n && port_free && bus.d_req && !if_win;
    assign issue  = if_win || d_win;

    // The select only moves on an issue; otherwise the mux stays where it was.
    assign addr_sel_out = issue ? d_win : addr_sel_reg;
    assign addr_mux     = addr_sel_out ? bus.d_addr : bus.if_addr;

    assign bus.if_gnt    = if_win;
    assign bus.d_gnt     = d_win;
    assign bus.addr_sel  = addr_sel_out;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = d_win && bus.d_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = bus.d_wdata;

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_ret
            assign rvalid_vec[gi] = ret_cycle && (owner_reg == (gi == 1));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? bus.mem_rdata : '0;
        end
    endgenerate

    assign bus.if_rvalid = rvalid_vec[0];
    assign bus.if_rdata  = rdata_vec[0];
    assign bus.d_rvalid  = rvalid_vec[1];
    assign bus.d_rdata   = rdata_vec[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            owner_reg    <= 1'b0;
            starve_reg   <= 4'd0;
            addr_sel_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            owner_reg    <= owner_next;
            starve_reg   <= starve_next;
            addr_sel_reg <= addr_sel_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        owner_next    = owner_reg;
        starve_next   = starve_reg;
        addr_sel_next = addr_sel_reg;

        if (issue) begin
            addr_sel_next = d_win;
            if (d_win && bus.d_we) begin
                // Writes complete at issue; nothing comes back.
                state_next = IDLE;
            end else begin
                state_next = WAIT;
                cnt_next   = CNT_INIT;
                owner_next = d_win;
            end
        end else if (state_reg == WAIT) begin
            if (cnt_reg != 3'd0) begin
                cnt_next = cnt_reg - 3'd1;
            end else begin
                state_next = IDLE;
            end
        end

        if (if_win) begin
            starve_next = 4'd0;
        end else if (bus.if_req) begin
            if (starve_reg != STARVE_LIM) begin
                starve_next = starve_reg + 4'd1;
            end
        end else begin
            starve_next = 4'd0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances at memory latencies 1, 2 and 3
// share one clock and reset and are exercised one after another.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    mem_port_arbiter_if #(.AW(8), .DW(16)) bus1 ();
    mem_port_arbiter_if #(.AW(8), .DW(16)) bus2 ();
    mem_port_arbiter_if #(.AW(8), .DW(16)) bus3 ();

    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(1), .STARVE_MAX(3)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(2), .STARVE_MAX(3)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );
    mem_port_arbiter #(.AW(8), .DW(16), .MEM_LAT(3), .STARVE_MAX(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle mid-cycle before sampling.
    task automatic settle;
        #4;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;

        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
        bus3.if_req = 0; bus3.if_addr = '0; bus3.d_req = 0; bus3.d_we = 0;
        bus3.d_addr = '0; bus3.d_wdata = '0; bus3.mem_rdata = '0;

        // Reset held with both requests active.
        rst_n = 0;
        bus2.if_req = 1; bus2.if_addr = 8'h10; bus2.d_req = 1; bus2.d_we = 0;
        bus2.d_addr = 8'h20; bus2.d_wdata = '0; bus2.mem_rdata = 16'h1234;
        #2;
        chk("rst_if_gnt",    bus2.if_gnt,    0);
        chk("rst_d_gnt",     bus2.d_gnt,     0);
        chk("rst_mem_en",    bus2.mem_en,    0);
        tick; tick; settle;
        chk("rst_if_rvalid", bus2.if_rvalid, 0);
        chk("rst_d_rvalid",  bus2.d_rvalid,  0);
        chk("rst_addr_sel",  bus2.addr_sel,  0);
        chk("rst_mem_we",    bus2.mem_we,    0);
        chk("rst_if_rdata",  bus2.if_rdata,  0);
        bus2.if_req = 0; bus2.d_req = 0;
        tick;
        rst_n = 1;

        // IF read 0x10, latency 2.
        tick;
        bus2.if_req = 1; bus2.if_addr = 8'h10;
        settle;
        chk("t2_if_gnt",    bus2.if_gnt,   1);
        chk("t2_d_gnt",     bus2.d_gnt,    0);
        chk("t2_mem_en",    bus2.mem_en,   1);
        chk("t2_mem_we",    bus2.mem_we,   0);
        chk("t2_addr_sel",  bus2.addr_sel, 0);
        chk("t2_mem_addr",  bus2.mem_addr, 8'h10);
        tick;
        bus2.if_req = 0;
        settle;
        chk("t2_wait_rvalid", bus2.if_rvalid, 0);
        chk("t2_wait_rdata",  bus2.if_rdata,  0);
        chk("t2_wait_mem_en", bus2.mem_en,    0);
        tick; settle;
        chk("t2_if_rvalid", bus2.if_rvalid, 1);
        chk("t2_if_rdata",  bus2.if_rdata,  16'h1234);
        chk("t2_d_rvalid",  bus2.d_rvalid,  0);
        tick; settle;
        chk("t2_after_rvalid", bus2.if_rvalid, 0);

        // Both request every cycle, D writes: three D grants, then IF on the fourth.
        tick;
        bus2.mem_rdata = 16'h5A5A;
        bus2.if_req = 1; bus2.if_addr = 8'h30;
        bus2.d_req = 1; bus2.d_we = 1; bus2.d_addr = 8'h20; bus2.d_wdata = 16'h1111;
        settle;
        chk("t3_c0_d_gnt",    bus2.d_gnt,     1);
        chk("t3_c0_if_gnt",   bus2.if_gnt,    0);
        chk("t3_c0_mem_we",   bus2.mem_we,    1);
        chk("t3_c0_addr_sel", bus2.addr_sel,  1);
        chk("t3_c0_mem_addr", bus2.mem_addr,  8'h20);
        chk("t3_c0_wdata",    bus2.mem_wdata, 16'h1111);
        tick;
        bus2.d_addr = 8'h21;
        settle;
        chk("t3_c1_d_gnt",  bus2.d_gnt,  1);
        chk("t3_c1_if_gnt", bus2.if_gnt, 0);
        tick;
        bus2.d_addr = 8'h22;
        settle;
        chk("t3_c2_d_gnt",  bus2.d_gnt,  1);
        chk("t3_c2_if_gnt", bus2.if_gnt, 0);
        tick;
        bus2.d_addr = 8'h23;
        settle;
        chk("t3_c3_if_gnt",   bus2.if_gnt,   1);
        chk("t3_c3_d_gnt",    bus2.d_gnt,    0);
        chk("t3_c3_addr_sel", bus2.addr_sel, 0);
        chk("t3_c3_mem_addr", bus2.mem_addr, 8'h30);
        chk("t3_c3_mem_we",   bus2.mem_we,   0);
        tick;
        bus2.if_req = 0;
        settle;
        chk("t3_busy_d_gnt",    bus2.d_gnt,    0);
        chk("t3_busy_mem_en",   bus2.mem_en,   0);
        chk("t3_busy_addr_sel", bus2.addr_sel, 0);
        tick; settle;
        chk("t3_ret_if_rvalid", bus2.if_rvalid, 1);
        chk("t3_ret_if_rdata",  bus2.if_rdata,  16'h5A5A);
        chk("t3_ret_d_gnt",     bus2.d_gnt,     1);
        chk("t3_ret_mem_we",    bus2.mem_we,    1);
        chk("t3_ret_d_rvalid",  bus2.d_rvalid,  0);
        tick;
        bus2.d_req = 0;
        settle;
        chk("t3_idle_if_rvalid", bus2.if_rvalid, 0);
        chk("t3_idle_d_rvalid",  bus2.d_rvalid,  0);
        chk("t3_idle_mem_en",    bus2.mem_en,    0);
        chk("t3_idle_addr_hold", bus2.addr_sel,  1);

        // D write 0xBEEF to 0x05 while IF also asks; IF follows next cycle.
        tick;
        bus2.if_req = 1; bus2.if_addr = 8'h40;
        bus2.d_req = 1; bus2.d_we = 1; bus2.d_addr = 8'h05; bus2.d_wdata = 16'hBEEF;
        settle;
        chk("t5_d_gnt",     bus2.d_gnt,     1);
        chk("t5_if_gnt",    bus2.if_gnt,    0);
        chk("t5_mem_en",    bus2.mem_en,    1);
        chk("t5_mem_we",    bus2.mem_we,    1);
        chk("t5_addr_sel",  bus2.addr_sel,  1);
        chk("t5_mem_addr",  bus2.mem_addr,  8'h05);
        chk("t5_mem_wdata", bus2.mem_wdata, 16'hBEEF);
        tick;
        bus2.d_req = 0;
        settle;
        chk("t5_next_if_gnt",   bus2.if_gnt,   1);
        chk("t5_next_addr_sel", bus2.addr_sel, 0);
        chk("t5_next_d_rvalid", bus2.d_rvalid, 0);
        chk("t5_next_mem_we",   bus2.mem_we,   0);
        tick;
        bus2.if_req = 0;
        settle;
        chk("t5_wait_d_rvalid", bus2.d_rvalid, 0);
        chk("t5_wait_addr_sel", bus2.addr_sel, 0);
        tick;
        bus2.mem_rdata = 16'h7777;
        settle;
        chk("t5_ret_if_rvalid", bus2.if_rvalid, 1);
        chk("t5_ret_if_rdata",  bus2.if_rdata,  16'h7777);
        chk("t5_ret_d_rvalid",  bus2.d_rvalid,  0);

        // Latency 1: D read then IF read back to back.
        tick;
        bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 8'h07;
        settle;
        chk("t4_d_gnt",    bus1.d_gnt,    1);
        chk("t4_addr_sel", bus1.addr_sel, 1);
        chk("t4_mem_we",   bus1.mem_we,   0);
        tick;
        bus1.d_req = 0; bus1.if_req = 1; bus1.if_addr = 8'h08; bus1.mem_rdata = 16'hCAFE;
        settle;
        chk("t4_d_rvalid",  bus1.d_rvalid,  1);
        chk("t4_d_rdata",   bus1.d_rdata,   16'hCAFE);
        chk("t4_if_rvalid", bus1.if_rvalid, 0);
        chk("t4_if_gnt",    bus1.if_gnt,    1);
        chk("t4_addr_sel0", bus1.addr_sel,  0);
        chk("t4_mem_addr",  bus1.mem_addr,  8'h08);
        tick;
        bus1.if_req = 0; bus1.mem_rdata = 16'h0BAD;
        settle;
        chk("t4_if_rvalid2", bus1.if_rvalid, 1);
        chk("t4_if_rdata",   bus1.if_rdata,  16'h0BAD);
        chk("t4_d_rvalid2",  bus1.d_rvalid,  0);
        chk("t4_d_rdata0",   bus1.d_rdata,   0);
        tick; settle;
        chk("t4_done_rvalid", bus1.if_rvalid, 0);

        // Latency 3: reset pulsed during the wait discards the in-flight read.
        tick;
        bus3.if_req = 1; bus3.if_addr = 8'h11; bus3.mem_rdata = 16'h3333;
        settle;
        chk("t6_if_gnt", bus3.if_gnt, 1);
        tick;
        bus3.if_req = 0; bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 8'h22;
        settle;
        chk("t6_busy_d_gnt", bus3.d_gnt, 0);
        rst_n = 0;
        #1;
        chk("t6_rst_d_gnt",  bus3.d_gnt,  0);
        chk("t6_rst_mem_en", bus3.mem_en, 0);
        bus3.d_req = 0;
        #1;
        rst_n = 1;
        tick;
        bus3.if_req = 1; bus3.if_addr = 8'h12;
        settle;
        chk("t6_new_if_gnt",   bus3.if_gnt,   1);
        chk("t6_new_mem_addr", bus3.mem_addr, 8'h12);
        chk("t6_new_rvalid",   bus3.if_rvalid, 0);
        tick;
        bus3.if_req = 0;
        settle;
        chk("t6_old_ret_rvalid", bus3.if_rvalid, 0);
        chk("t6_old_ret_drv",    bus3.d_rvalid,  0);
        tick; settle;
        chk("t6_wait2_rvalid", bus3.if_rvalid, 0);
        tick; settle;
        chk("t6_ret_rvalid", bus3.if_rvalid, 1);
        chk("t6_ret_rdata",  bus3.if_rdata,  16'h3333);
        tick; settle;
        chk("t6_end_rvalid", bus3.if_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
